spi_input_frontend: RTL and testbench

- Upstream conditioning stage for the SPI memory controller FSM.
- Takes the raw asynchronous SPI pins (sclk, cs, mosi) and produces glitch-filtered, clk-synchronous levels.
- Also produces single-cycle sclk rising/falling pulses; these drive the FSM's posclkedge/negclkedge inputs.
- Built from three instances of one per-channel conditioner.

---
 rtl/spi_input_frontend_pkg.sv | 13 +
 rtl/spi_input_frontend_input_conditioner.sv | 78 +++++++
 rtl/spi_input_frontend.sv | 49 ++++
 tb/tb_spi_input_frontend.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_input_frontend_pkg.sv
// Shared constants for the SPI input frontend: per-channel reset levels and
// default conditioner parameters.
package spi_input_frontend_pkg;

  localparam logic SCLK_RST = 1'b0;
  localparam logic CS_RST   = 1'b1;
  localparam logic MOSI_RST = 1'b0;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_COUNTER_WIDTH = 3;
  localparam int DEF_WAIT_TIME     = 3;

endpackage

// File: rtl/spi_input_frontend_input_conditioner.sv
// Per-channel conditioner: synchronizer, debounce filter, registered edge pulses.
// SPI_FRONTEND_BYPASS_DEBOUNCE_EN removes the debounce counter (sync only).
module input_conditioner #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   COUNTER_WIDTH = 3,
  parameter int   WAIT_TIME     = 3,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (WAIT_TIME > (2 ** COUNTER_WIDTH) - 1) begin : g_bad_wait
    $error("WAIT_TIME does not fit in COUNTER_WIDTH bits");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisysignal};
    end
  end

`ifdef SPI_FRONTEND_BYPASS_DEBOUNCE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conditioned  <= RESET_VAL;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      conditioned  <= sync_out;
      positiveedge <= sync_out & ~conditioned;
      negativeedge <= ~sync_out & conditioned;
    end
  end
`else
  localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);

  logic [COUNTER_WIDTH-1:0] count;

  // A mismatch must survive WAIT_TIME further edges before the level is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conditioned  <= RESET_VAL;
      count        <= '0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      if (sync_out == conditioned) begin
        count <= '0;
      end else if (count == WAIT_CNT) begin
        conditioned  <= sync_out;
        count        <= '0;
        positiveedge <= sync_out;
        negativeedge <= ~sync_out;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/spi_input_frontend.sv
// SPI pin frontend: three independent conditioners for sclk, cs and mosi.
// Optional macro SPI_FRONTEND_BYPASS_DEBOUNCE_EN selects synchronize-only mode.
module spi_input_frontend
  import spi_input_frontend_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int WAIT_TIME     = DEF_WAIT_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sclk_cond,
  output logic cs_cond,
  output logic mosi_cond,
  output logic posclkedge,
  output logic negclkedge
);

  // Edge pulses exist only for sclk; the other channels' pulses are dropped.
  logic [3:0] unused_edges;

  input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .COUNTER_WIDTH(COUNTER_WIDTH),
    .WAIT_TIME(WAIT_TIME), .RESET_VAL(SCLK_RST)
  ) u_sclk (
    .clk(clk), .reset(reset), .noisysignal(sclk_pin),
    .conditioned(sclk_cond), .positiveedge(posclkedge), .negativeedge(negclkedge)
  );

  input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .COUNTER_WIDTH(COUNTER_WIDTH),
    .WAIT_TIME(WAIT_TIME), .RESET_VAL(CS_RST)
  ) u_cs (
    .clk(clk), .reset(reset), .noisysignal(cs_pin),
    .conditioned(cs_cond), .positiveedge(unused_edges[0]), .negativeedge(unused_edges[1])
  );

  input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .COUNTER_WIDTH(COUNTER_WIDTH),
    .WAIT_TIME(WAIT_TIME), .RESET_VAL(MOSI_RST)
  ) u_mosi (
    .clk(clk), .reset(reset), .noisysignal(mosi_pin),
    .conditioned(mosi_cond), .positiveedge(unused_edges[2]), .negativeedge(unused_edges[3])
  );

endmodule

// File: tb/tb_spi_input_frontend.sv
// Bench for spi_input_frontend: vector table, directed timing sequences and
// randomized pins checked against a sliding-window reference model.
module tb_spi_input_frontend;
  import spi_input_frontend_pkg::*;

  localparam int SYNC  = DEF_SYNC_STAGES;
  localparam int WAIT  = DEF_WAIT_TIME;
`ifdef SPI_FRONTEND_BYPASS_DEBOUNCE_EN
  localparam bit BYP = 1'b1;
  localparam int WIN = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int WIN = WAIT + 1;
`endif
  localparam int LAT   = SYNC + WIN;
  localparam int DEPTH = SYNC + WAIT + 1;
  localparam logic [2:0] RSTV = {MOSI_RST, CS_RST, SCLK_RST};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sclk_pin = SCLK_RST, cs_pin = CS_RST, mosi_pin = MOSI_RST;
  logic sclk_cond, cs_cond, mosi_cond, posclkedge, negclkedge;

  always #5 clk = ~clk;

  spi_input_frontend dut (
    .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .sclk_cond(sclk_cond), .cs_cond(cs_cond), .mosi_cond(mosi_cond),
    .posclkedge(posclkedge), .negclkedge(negclkedge)
  );

  int checks = 0;
  int errors = 0;
  int pos_cnt, neg_cnt;

  // Model: a channel's level flips once the last WIN synchronized samples all disagree with it.
  logic       hist [3][DEPTH];
  logic [2:0] m_cond;
  logic       m_pos, m_neg;

  typedef struct {
    logic [2:0] pins;
    int         hold;
    logic [2:0] exp_cond;
    int         exp_pos;
    int         exp_neg;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < DEPTH; k++) hist[c][k] = RSTV[c];
    m_cond = RSTV;
    m_pos  = 1'b0;
    m_neg  = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] pins;
    logic       all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    pins  = {mosi_pin, cs_pin, sclk_pin};
    m_pos = 1'b0;
    m_neg = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = DEPTH - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = pins[c];
      all_diff = 1'b1;
      for (int k = SYNC; k < SYNC + WIN; k++)
        if (hist[c][k] == m_cond[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_cond[c] = ~m_cond[c];
        if (c == 0) begin
          m_pos = m_cond[0];
          m_neg = ~m_cond[0];
        end
      end
    end
  endtask

  task automatic cmp_outputs();
    chk("sclk_cond", sclk_cond, m_cond[0]);
    chk("cs_cond", cs_cond, m_cond[1]);
    chk("mosi_cond", mosi_cond, m_cond[2]);
    chk("posclkedge", posclkedge, m_pos);
    chk("negclkedge", negclkedge, m_neg);
    chk("pulse_exclusive", posclkedge & negclkedge, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_outputs();
    if (posclkedge === 1'b1) pos_cnt++;
    if (negclkedge === 1'b1) neg_cnt++;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_sclk_cond", sclk_cond, SCLK_RST);
    chk("rst_cs_cond", cs_cond, CS_RST);
    chk("rst_mosi_cond", mosi_cond, MOSI_RST);
    chk("rst_pulses", {posclkedge, negclkedge}, 0);
  endtask

  initial begin
    int n, pos_at, neg_at;
    #600000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pos_at, neg_at;
    tbl[0] = '{3'b010, 20, 3'b010, 0, 0};
    tbl[1] = '{3'b011, 10, 3'b011, 1, 0};
    tbl[2] = '{3'b010, 10, 3'b010, 0, 1};
    tbl[3] = '{3'b011,  3, BYP ? 3'b011 : 3'b010, BYP ? 1 : 0, 0};
    tbl[4] = '{3'b010, 10, 3'b010, 0, BYP ? 1 : 0};
    tbl[5] = '{3'b100, 10, 3'b100, 0, 0};
    tbl[6] = '{3'b010, 10, 3'b010, 0, 0};

    #2;
    assert_reset();
    repeat (3) cyc();
    reset = 1'b0;

    // Vector table
    foreach (tbl[i]) begin
      {mosi_pin, cs_pin, sclk_pin} = tbl[i].pins;
      pos_cnt = 0;
      neg_cnt = 0;
      repeat (tbl[i].hold) cyc();
      chk($sformatf("tbl%0d_cond", i), {mosi_cond, cs_cond, sclk_cond}, tbl[i].exp_cond);
      chk($sformatf("tbl%0d_pos", i), pos_cnt, tbl[i].exp_pos);
      chk($sformatf("tbl%0d_neg", i), neg_cnt, tbl[i].exp_neg);
    end

    // Rising/falling latency and pulse width
    sclk_pin = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (posclkedge !== 1'b1 && n < 20);
    chk("pos_latency", n, LAT);
    cyc();
    chk("pos_width", posclkedge, 0);
    repeat (8) cyc();
    sclk_pin = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (negclkedge !== 1'b1 && n < 20);
    chk("neg_latency", n, LAT);
    cyc();
    chk("neg_width", negclkedge, 0);
    repeat (8) cyc();

    // Simultaneous cs/mosi change
    cs_pin = 1'b0;
    mosi_pin = 1'b1;
    pos_cnt = 0;
    neg_cnt = 0;
    n = 0;
    do begin cyc(); n++; end while (cs_cond !== 1'b0 && n < 20);
    chk("cs_latency", n, LAT);
    chk("mosi_same_edge", mosi_cond, 1);
    repeat (4) cyc();
    chk("no_sclk_pulse_cs_mosi", pos_cnt + neg_cnt, 0);
    cs_pin = 1'b1;
    mosi_pin = 1'b0;
    repeat (10) cyc();

    // Reset in the middle of a debounce count, released with sclk high
    sclk_pin = 1'b1;
    repeat (SYNC + 2) cyc();
    @(posedge clk);
    #2;
    assert_reset();
    model_edge();
    @(negedge clk);
    repeat (2) cyc();
    reset = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (posclkedge !== 1'b1 && n < 20);
    chk("rst_release_latency", n, LAT);
    sclk_pin = 1'b0;
    repeat (10) cyc();

    // One-cycle sclk pulse: passes only in bypass mode
    sclk_pin = 1'b1;
    pos_at = 0;
    neg_at = 0;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      sclk_pin = 1'b0;
      if (posclkedge === 1'b1 && pos_at == 0) pos_at = e;
      if (negclkedge === 1'b1 && neg_at == 0) neg_at = e;
    end
    chk("short_pulse_pos_edge", pos_at, BYP ? SYNC + 1 : 0);
    chk("short_pulse_neg_edge", neg_at, BYP ? SYNC + 2 : 0);

    // Randomized pins with occasional asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 249) == 0) begin
        #1;
        assert_reset();
      end
      if ($urandom_range(0, 5) == 0) sclk_pin = ~sclk_pin;
      if ($urandom_range(0, 5) == 0) cs_pin   = ~cs_pin;
      if ($urandom_range(0, 5) == 0) mosi_pin = ~mosi_pin;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
